// File: rtl/encoder_8_to_3_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_to_3_arb_pkg
// Description : Shared widths, FSM state encoding and index helper for the
//               registered 8-to-3 priority encoder/arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_8_to_3_arb_pkg;

   localparam int REQ_W = 8;
   localparam int IDX_W = 3;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   function automatic logic [REQ_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
      return REQ_W'(1) << i;
   endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_8_to_3_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_to_3_arb_if
// Description : Request/valid/ack bundle between request sources, consumer
//               and the encoder/arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface encoder_8_to_3_arb_if;
   import encoder_8_to_3_arb_pkg::*;

   logic [REQ_W-1:0] req;
   logic             ack;
   logic             valid;
   logic [IDX_W-1:0] idx;
   logic [REQ_W-1:0] pending;
   logic             overflow;

   modport master (
      output req,
      output ack,
      input  valid,
      input  idx,
      input  pending,
      input  overflow
   );

   modport slave (
      input  req,
      input  ack,
      output valid,
      output idx,
      output pending,
      output overflow
   );

endinterface
`default_nettype wire

// File: rtl/encoder_8_to_3_arb_prio_enc_8.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_8
// Description : Combinational 8-bit priority encoder; HIGH_FIRST selects
//               whether bit 7 or bit 0 wins.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_8
   import encoder_8_to_3_arb_pkg::*;
#(
   parameter int HIGH_FIRST = 1
) (
   input  logic [REQ_W-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Later matches overwrite earlier ones, so the scan order decides priority.
   always_comb begin
      idx = '0;
      any = |vec;
      if (HIGH_FIRST != 0) begin
         for (int i = 0; i < REQ_W; i++) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/encoder_8_to_3_arb.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_to_3_arb
// Description : Registered 8-to-3 priority encoder with request latching,
//               sticky overflow and a non-preemptive valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8_to_3_arb
   import encoder_8_to_3_arb_pkg::*;
#(
   parameter int HIGH_FIRST = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   encoder_8_to_3_arb_if.slave  bus
);

   state_t           state_q;
   logic             valid_q;
   logic [IDX_W-1:0] idx_q;
   logic [REQ_W-1:0] pending_q;
   logic [REQ_W-1:0] pending_d;
   logic             overflow_q;
   logic             overflow_d;
   logic [REQ_W-1:0] clr;
   logic [IDX_W-1:0] winner;
   logic             any_pending;

   // A request landing on the bit being cleared re-sets it (set wins) and
   // is not an overflow, since the earlier instance was consumed this cycle.
   always_comb begin
      clr = '0;
      if (valid_q && bus.ack) clr = idx_to_onehot(idx_q);
      pending_d  = (pending_q & ~clr) | bus.req;
      overflow_d = overflow_q | (|(bus.req & pending_q & ~clr));
   end

   prio_enc_8 #(
      .HIGH_FIRST (HIGH_FIRST)
   ) u_prio_enc (
      .vec (pending_d),
      .idx (winner),
      .any (any_pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         case (state_q)
            ST_IDLE: begin
               if (any_pending) begin
                  idx_q   <= winner;
                  valid_q <= 1'b1;
                  state_q <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               // Index only moves on ack; new requests never preempt it.
               if (bus.ack) begin
                  if (any_pending) begin
                     idx_q <= winner;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.valid    = valid_q;
   assign bus.idx      = idx_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_8_to_3_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_8_to_3_arb
// Description : Self-checking bench for both priority orders: directed
//               literal checks plus a randomized run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_8_to_3_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       ack = 1'b0;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   encoder_8_to_3_arb_if bus_a ();
   encoder_8_to_3_arb_if bus_b ();

   assign bus_a.req = req;
   assign bus_a.ack = ack;
   assign bus_b.req = req;
   assign bus_b.ack = ack;

   encoder_8_to_3_arb #(.HIGH_FIRST(1)) u_dut_hi (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   encoder_8_to_3_arb #(.HIGH_FIRST(0)) u_dut_lo (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // ---------------- behavioural model ----------------
   function automatic int msb_pos(input int v);
      int n = 0;
      while (v > 1) begin
         v = v >> 1;
         n++;
      end
      return n;
   endfunction

   function automatic int lsb_pos(input int v);
      return msb_pos(v & -v);
   endfunction

   // index 0 = HIGH_FIRST=1 model, index 1 = HIGH_FIRST=0 model
   int m_pend  [2];
   int m_idx   [2];
   bit m_valid [2];
   bit m_ovf   [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int c;
         int nxt;
         if (rst) begin
            m_pend[k]  = 0;
            m_idx[k]   = 0;
            m_valid[k] = 0;
            m_ovf[k]   = 0;
         end else begin
            c   = (m_valid[k] && ack) ? (1 << m_idx[k]) : 0;
            if ((int'(req) & m_pend[k] & ~c) != 0) m_ovf[k] = 1;
            nxt = (m_pend[k] & ~c) | int'(req);
            if (!m_valid[k] || ack) begin
               if (nxt != 0) begin
                  m_valid[k] = 1;
                  m_idx[k]   = (k == 0) ? msb_pos(nxt) : lsb_pos(nxt);
               end else begin
                  m_valid[k] = 0;
               end
            end
            m_pend[k] = nxt;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mdl_hi_valid", {7'd0, bus_a.valid},    {7'd0, m_valid[0]});
         chk("mdl_hi_idx",   {5'd0, bus_a.idx},      8'(m_idx[0]));
         chk("mdl_hi_pend",  bus_a.pending,          8'(m_pend[0]));
         chk("mdl_hi_ovf",   {7'd0, bus_a.overflow}, {7'd0, m_ovf[0]});
         chk("mdl_lo_valid", {7'd0, bus_b.valid},    {7'd0, m_valid[1]});
         chk("mdl_lo_idx",   {5'd0, bus_b.idx},      8'(m_idx[1]));
         chk("mdl_lo_pend",  bus_b.pending,          8'(m_pend[1]));
         chk("mdl_lo_ovf",   {7'd0, bus_b.overflow}, {7'd0, m_ovf[1]});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hi(input string name, input bit v, input int i, input logic [7:0] p);
      chk({name, "_hi_valid"}, {7'd0, bus_a.valid}, {7'd0, v});
      if (v) chk({name, "_hi_idx"}, {5'd0, bus_a.idx}, 8'(i));
      chk({name, "_hi_pend"}, bus_a.pending, p);
   endtask

   task automatic chk_lo(input string name, input bit v, input int i, input logic [7:0] p);
      chk({name, "_lo_valid"}, {7'd0, bus_b.valid}, {7'd0, v});
      if (v) chk({name, "_lo_idx"}, {5'd0, bus_b.idx}, 8'(i));
      chk({name, "_lo_pend"}, bus_b.pending, p);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      // Reset with all requests asserted: they must be ignored.
      rst = 1'b1; req = 8'hFF; ack = 1'b0;
      tick();
      mon_en = 1'b1;
      chk_hi("rst1", 0, 0, 8'h00);
      chk("rst1_ovf", {7'd0, bus_a.overflow}, 8'h00);
      chk("rst1_idx", {5'd0, bus_a.idx}, 8'h00);
      tick();
      chk_hi("rst2", 0, 0, 8'h00);
      rst = 1'b0; req = 8'h00;
      tick();
      chk_hi("post_rst", 0, 0, 8'h00);

      // Single request and ack.
      req = 8'h20;
      tick();
      chk_hi("single", 1, 5, 8'h20);
      chk_lo("single", 1, 5, 8'h20);
      req = 8'h00; ack = 1'b1;
      tick();
      chk_hi("single_ack", 0, 0, 8'h00);
      ack = 1'b0;

      // Priority order and back-to-back drain with ack held.
      req = 8'h85; ack = 1'b1;
      tick();
      chk_hi("drain0", 1, 7, 8'h85);
      chk_lo("drain0", 1, 0, 8'h85);
      req = 8'h00;
      tick();
      chk_hi("drain1", 1, 2, 8'h05);
      chk_lo("drain1", 1, 2, 8'h84);
      tick();
      chk_hi("drain2", 1, 0, 8'h01);
      chk_lo("drain2", 1, 7, 8'h80);
      tick();
      chk_hi("drain3", 0, 0, 8'h00);
      chk_lo("drain3", 0, 0, 8'h00);
      ack = 1'b0;

      // No preemption by a higher-priority request.
      req = 8'h02;
      tick();
      chk_hi("nopre0", 1, 1, 8'h02);
      req = 8'h00;
      tick();
      tick();
      chk_hi("nopre1", 1, 1, 8'h02);
      req = 8'h80;
      tick();
      chk_hi("nopre2", 1, 1, 8'h82);
      req = 8'h00; ack = 1'b1;
      tick();
      chk_hi("nopre3", 1, 7, 8'h80);
      tick();
      chk_hi("nopre4", 0, 0, 8'h00);
      chk("nopre_ovf", {7'd0, bus_a.overflow}, 8'h00);
      ack = 1'b0;

      // Collision with the presented bit, then a true overflow.
      req = 8'h08;
      tick();
      chk_hi("coll0", 1, 3, 8'h08);
      req = 8'h08; ack = 1'b1;
      tick();
      chk_hi("coll1", 1, 3, 8'h08);
      chk("coll1_ovf", {7'd0, bus_a.overflow}, 8'h00);
      ack = 1'b0;
      tick();
      chk("ovf_set", {7'd0, bus_a.overflow}, 8'h01);
      chk("ovf_set_lo", {7'd0, bus_b.overflow}, 8'h01);
      req = 8'h00;
      tick();
      ack = 1'b1;
      tick();
      chk_hi("ovf_drain", 0, 0, 8'h00);
      chk("ovf_sticky", {7'd0, bus_a.overflow}, 8'h01);
      ack = 1'b0; rst = 1'b1;
      tick();
      chk("ovf_cleared", {7'd0, bus_a.overflow}, 8'h00);
      rst = 1'b0;

      // Encoder/decoder loop over all single-bit requests.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] onehot;
         logic [7:0] decoded;
         onehot = 8'h01 << i;
         req = onehot;
         tick();
         decoded = 8'h01 << bus_a.idx;
         chk("loop_valid", {7'd0, bus_a.valid}, 8'h01);
         chk("loop_decode", decoded, onehot);
         req = 8'h00; ack = 1'b1;
         tick();
         ack = 1'b0;
         chk("loop_clear", bus_a.pending, 8'h00);
      end

      // Randomized traffic, occasional reset; the monitor checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] r;
         r = '0;
         for (int b = 0; b < 8; b++) r[b] = ($urandom_range(0, 9) == 0);
         req = r;
         ack = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; req = 8'h00; ack = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
